// File: rtl/sobel_mdc_ctrl_package.sv
// Shared types for the Sobel MDC job controller:
// FSM state, control and status bundles.
package sobel_mdc_ctrl_package;

  localparam int SOBEL_MDC_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_SIZE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } sobel_mdc_ctrl_state_t;

  typedef struct packed {
    logic                           start;
    logic                           clear;
    logic [SOBEL_MDC_CNT_WIDTH-1:0] img_w;
    logic [SOBEL_MDC_CNT_WIDTH-1:0] img_h;
  } ctrl_sobel_mdc_job_t;

  typedef struct packed {
    logic                             busy;
    logic                             idle;
    logic                             done;
    logic                             err;
    logic [2*SOBEL_MDC_CNT_WIDTH-1:0] cnt_in;
    logic [2*SOBEL_MDC_CNT_WIDTH-1:0] cnt_out;
  } flags_sobel_mdc_job_t;

endpackage

// File: rtl/sobel_mdc_hs_counter.sv
// Handshake counter: clearable, saturates at i_max,
// exposes current and next-cycle terminal count.
module sobel_mdc_hs_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_clr,
  input  logic             i_hs,
  input  logic [WIDTH-1:0] i_max,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_tc_nxt
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_inc;

  assign o_tc      = (r_cnt == i_max);
  assign w_inc     = i_hs & ~o_tc;
  assign w_cnt_nxt = w_inc ? r_cnt + WIDTH'(1)
                           : r_cnt;
  assign o_tc_nxt  = (w_cnt_nxt == i_max);
  assign o_cnt     = r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/sobel_mdc_job_ctrl.sv
// Frame-accurate job sequencer between the HWPE
// streamer and the Sobel MDC datapath.
module sobel_mdc_job_ctrl
  import sobel_mdc_ctrl_package::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = SOBEL_MDC_CNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   img_w_i,
  input  logic [CNT_WIDTH-1:0]   img_h_i,
  output logic                   size_valid_o,
  output logic [DATA_WIDTH-1:0]  size_data_o,
  input  logic                   size_ready_i,
  input  logic                   pel_in_valid_i,
  output logic                   pel_in_ready_o,
  output logic                   pel_out_valid_o,
  input  logic                   pel_out_ready_i,
  input  logic                   res_valid_i,
  input  logic                   res_ready_i,
  output logic                   busy_o,
  output logic                   idle_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [2*CNT_WIDTH-1:0] cnt_in_o,
  output logic [2*CNT_WIDTH-1:0] cnt_out_o
);

  localparam int TW = 2 * CNT_WIDTH;
  localparam int PW = 2 * SOBEL_MDC_CNT_WIDTH;

  ctrl_sobel_mdc_job_t   w_ctrl;
  flags_sobel_mdc_job_t  w_flags;
  sobel_mdc_ctrl_state_t r_state;
  sobel_mdc_ctrl_state_t w_state_nxt;

  logic [CNT_WIDTH-1:0] r_w;
  logic [CNT_WIDTH-1:0] r_h;
  logic [TW-1:0]        r_total;
  logic                 r_err;

  logic [TW-1:0] w_total;
  logic [TW-1:0] w_cnt_in;
  logic [TW-1:0] w_cnt_out;
  logic          w_start_acc;
  logic          w_cnt_clr;
  logic          w_gate;
  logic          w_pel_hs;
  logic          w_res_hs;
  logic          w_res_en;
  logic          w_err_evt;
  logic          w_in_tc;
  logic          w_in_tc_nxt;
  logic          w_out_tc;
  logic          w_out_tc_nxt;

  always_comb begin
    w_ctrl       = '0;
    w_ctrl.start = start_i;
    w_ctrl.clear = clear_i;
    w_ctrl.img_w = SOBEL_MDC_CNT_WIDTH'(img_w_i);
    w_ctrl.img_h = SOBEL_MDC_CNT_WIDTH'(img_h_i);
  end

  assign w_total = TW'(w_ctrl.img_w)
                 * TW'(w_ctrl.img_h);

  assign w_start_acc = w_ctrl.start
                     & (r_state == ST_IDLE);
  assign w_cnt_clr   = w_ctrl.clear | w_start_acc;

  // In-counter terminal count also closes the gate
  assign w_gate   = (r_state == ST_STREAM) & ~w_in_tc;
  assign w_pel_hs = w_gate & pel_in_valid_i
                  & pel_out_ready_i;

  assign w_res_hs  = res_valid_i & res_ready_i;
  assign w_res_en  = w_res_hs & (r_state != ST_IDLE);
  assign w_err_evt = w_res_hs
                   & ((r_state == ST_IDLE) | w_out_tc);

  sobel_mdc_hs_counter #(
    .WIDTH (TW)
  ) u_cnt_in (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_clr    (w_cnt_clr),
    .i_hs     (w_pel_hs),
    .i_max    (r_total),
    .o_cnt    (w_cnt_in),
    .o_tc     (w_in_tc),
    .o_tc_nxt (w_in_tc_nxt)
  );

  sobel_mdc_hs_counter #(
    .WIDTH (TW)
  ) u_cnt_out (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_clr    (w_cnt_clr),
    .i_hs     (w_res_en),
    .i_max    (r_total),
    .o_cnt    (w_cnt_out),
    .o_tc     (w_out_tc),
    .o_tc_nxt (w_out_tc_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ctrl.start) begin
          w_state_nxt = (w_total == '0) ? ST_DONE
                                        : ST_SEND_SIZE;
        end
      end
      ST_SEND_SIZE: begin
        if (size_ready_i) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_pel_hs & w_in_tc_nxt) begin
          w_state_nxt = w_out_tc_nxt ? ST_DONE
                                     : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_out_tc_nxt) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_ctrl.clear) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_w     <= '0;
      r_h     <= '0;
      r_total <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc & ~w_ctrl.clear) begin
        r_w     <= CNT_WIDTH'(w_ctrl.img_w);
        r_h     <= CNT_WIDTH'(w_ctrl.img_h);
        r_total <= w_total;
      end
    end
  end

  // A stray result in the start cycle still flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_ctrl.clear) begin
      r_err <= 1'b0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end
  end

  always_comb begin
    w_flags         = '0;
    w_flags.busy    = (r_state != ST_IDLE);
    w_flags.idle    = (r_state == ST_IDLE);
    w_flags.done    = (r_state == ST_DONE);
    w_flags.err     = r_err;
    w_flags.cnt_in  = PW'(w_cnt_in);
    w_flags.cnt_out = PW'(w_cnt_out);
  end

  assign busy_o    = w_flags.busy;
  assign idle_o    = w_flags.idle;
  assign done_o    = w_flags.done;
  assign err_o     = w_flags.err;
  assign cnt_in_o  = TW'(w_flags.cnt_in);
  assign cnt_out_o = TW'(w_flags.cnt_out);

  assign size_valid_o    = (r_state == ST_SEND_SIZE);
  assign size_data_o     = DATA_WIDTH'({r_h, r_w});
  assign pel_out_valid_o = w_gate & pel_in_valid_i;
  assign pel_in_ready_o  = w_gate & pel_out_ready_i;

endmodule

// File: tb/tb_sobel_mdc_job_ctrl.sv
// Randomized bench for sobel_mdc_job_ctrl with a
// job-level reference model and scenario tasks.
module tb_sobel_mdc_job_ctrl;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i, start_i;
  logic [CW-1:0] img_w_i, img_h_i;
  logic          size_valid_o, size_ready_i;
  logic [DW-1:0] size_data_o;
  logic          pel_in_valid_i, pel_in_ready_o;
  logic          pel_out_valid_o, pel_out_ready_i;
  logic          res_valid_i, res_ready_i;
  logic          busy_o, idle_o, done_o, err_o;
  logic [TW-1:0] cnt_in_o, cnt_out_o;

  int total_n = 0;
  int bad_n   = 0;
  bit mon_en  = 1'b0;

  always #5 clk_i = ~clk_i;

  sobel_mdc_job_ctrl #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .start_i         (start_i),
    .img_w_i         (img_w_i),
    .img_h_i         (img_h_i),
    .size_valid_o    (size_valid_o),
    .size_data_o     (size_data_o),
    .size_ready_i    (size_ready_i),
    .pel_in_valid_i  (pel_in_valid_i),
    .pel_in_ready_o  (pel_in_ready_o),
    .pel_out_valid_o (pel_out_valid_o),
    .pel_out_ready_i (pel_out_ready_i),
    .res_valid_i     (res_valid_i),
    .res_ready_i     (res_ready_i),
    .busy_o          (busy_o),
    .idle_o          (idle_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .cnt_in_o        (cnt_in_o),
    .cnt_out_o       (cnt_out_o)
  );

  // Job-level model: busy job, size owed, done cycle
  typedef struct packed {
    logic          busy;
    logic          pend;
    logic          done;
    logic          err;
    logic [TW-1:0] tot;
    logic [TW-1:0] nin;
    logic [TW-1:0] nout;
    logic [CW-1:0] w;
    logic [CW-1:0] h;
  } mdl_t;

  mdl_t m = '0;

  function automatic logic mgate(input mdl_t s);
    return s.busy && !s.pend && !s.done
        && (s.nin < s.tot);
  endfunction

  function automatic mdl_t model_next(input mdl_t s);
    mdl_t n;
    logic rh;
    n  = s;
    rh = res_valid_i && res_ready_i;
    if (clear_i) begin
      n.busy = 0; n.pend = 0; n.done = 0;
      n.err  = 0; n.nin  = 0; n.nout = 0;
    end else if (!s.busy) begin
      if (rh) n.err = 1;
      if (start_i) begin
        n.nin  = 0;
        n.nout = 0;
        n.err  = rh;
        n.w    = img_w_i;
        n.h    = img_h_i;
        n.tot  = TW'(img_w_i) * TW'(img_h_i);
        n.busy = 1;
        n.pend = (n.tot != 0);
        n.done = (n.tot == 0);
      end
    end else if (s.done) begin
      n.busy = 0;
      n.done = 0;
      if (rh) n.err = 1;
    end else begin
      if (s.pend && size_ready_i) n.pend = 0;
      if (rh) begin
        if (s.nout < s.tot) n.nout = s.nout + 1;
        else n.err = 1;
      end
      if (mgate(s) && pel_in_valid_i
          && pel_out_ready_i)
        n.nin = s.nin + 1;
      if (!n.pend && n.nin == n.tot
          && n.nout == n.tot)
        n.done = 1;
    end
    return n;
  endfunction

  initial begin : model_proc
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) m = '0;
      else m = model_next(m);
    end
  end

  initial begin : monitor_proc
    logic g;
    logic [DW-1:0] sd;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        g = mgate(m);
        total_n++;
        if (idle_o !== !m.busy) begin
          bad_n++;
          $display("FAIL mon_idle t=%0t got=%b exp=%b",
                   $time, idle_o, !m.busy);
        end
        total_n++;
        if (busy_o !== m.busy) begin
          bad_n++;
          $display("FAIL mon_busy t=%0t got=%b exp=%b",
                   $time, busy_o, m.busy);
        end
        total_n++;
        if (done_o !== m.done) begin
          bad_n++;
          $display("FAIL mon_done t=%0t got=%b exp=%b",
                   $time, done_o, m.done);
        end
        total_n++;
        if (err_o !== m.err) begin
          bad_n++;
          $display("FAIL mon_err t=%0t got=%b exp=%b",
                   $time, err_o, m.err);
        end
        total_n++;
        if (size_valid_o !== (m.busy && m.pend)) begin
          bad_n++;
          $display("FAIL mon_szv t=%0t got=%b exp=%b",
                   $time, size_valid_o,
                   m.busy && m.pend);
        end
        if (m.busy && m.pend) begin
          sd = DW'({m.h, m.w});
          total_n++;
          if (size_data_o !== sd) begin
            bad_n++;
            $display("FAIL mon_szd t=%0t got=%h exp=%h",
                     $time, size_data_o, sd);
          end
        end
        total_n++;
        if (pel_in_ready_o !== (g && pel_out_ready_i)) begin
          bad_n++;
          $display("FAIL mon_prdy t=%0t got=%b exp=%b",
                   $time, pel_in_ready_o,
                   g && pel_out_ready_i);
        end
        total_n++;
        if (pel_out_valid_o !== (g && pel_in_valid_i)) begin
          bad_n++;
          $display("FAIL mon_pvld t=%0t got=%b exp=%b",
                   $time, pel_out_valid_o,
                   g && pel_in_valid_i);
        end
        total_n++;
        if (cnt_in_o !== m.nin) begin
          bad_n++;
          $display("FAIL mon_cin t=%0t got=%0d exp=%0d",
                   $time, cnt_in_o, m.nin);
        end
        total_n++;
        if (cnt_out_o !== m.nout) begin
          bad_n++;
          $display("FAIL mon_cout t=%0t got=%0d exp=%0d",
                   $time, cnt_out_o, m.nout);
        end
      end
    end
  end

  int s_size, s_sv, s_pix, s_res, s_done;
  int s_done_cyc, s_last_res, s_last_pix;
  int s_unstable, s_early, s_blocked;
  logic [DW-1:0] s_word;

  task automatic drive_idle();
    start_i         = 0;
    clear_i         = 0;
    img_w_i         = '0;
    img_h_i         = '0;
    size_ready_i    = 0;
    pel_in_valid_i  = 0;
    pel_out_ready_i = 0;
    res_valid_i     = 0;
    res_ready_i     = 0;
  endtask

  function automatic bit rnd(input int p);
    return $urandom_range(1, 100) <= p;
  endfunction

  task automatic run_job(
    input int w, input int h,
    input int pin_p, input int pout_p,
    input int res_p, input int stall,
    input int mid_at, input int clr_at,
    input bit extra
  );
    int  cyc, clr_cyc, tot;
    bit  seen, mid_done, pv;
    logic [DW-1:0] sd;
    s_size = 0; s_sv = 0; s_pix = 0; s_res = 0;
    s_done = 0; s_done_cyc = -1;
    s_last_res = -1; s_last_pix = -1;
    s_unstable = 0; s_early = 0; s_blocked = 0;
    s_word = '0;
    tot = w * h;
    cyc = 0; clr_cyc = -1;
    seen = 0; mid_done = 0; pv = 0; sd = '0;
    while (!seen && cyc < 400) begin
      @(posedge clk_i); #1;
      start_i = (cyc == 0);
      clear_i = 0;
      img_w_i = (cyc == 0) ? CW'(w)
                           : CW'($urandom_range(0, 15));
      img_h_i = (cyc == 0) ? CW'(h)
                           : CW'($urandom_range(0, 15));
      if (mid_at >= 0 && s_pix == mid_at
          && !mid_done) begin
        start_i  = 1;
        img_w_i  = 2;
        img_h_i  = 2;
        mid_done = 1;
      end
      size_ready_i    = (cyc > stall);
      pel_in_valid_i  = rnd(pin_p);
      pel_out_ready_i = rnd(pout_p);
      res_valid_i     = (extra || s_res < s_pix)
                        && rnd(res_p);
      res_ready_i     = rnd(res_p);
      if (clr_at >= 0 && s_pix == clr_at
          && clr_cyc < 0) begin
        clear_i        = 1;
        pel_in_valid_i = 0;
        res_valid_i    = 0;
        clr_cyc        = cyc;
      end
      @(negedge clk_i);
      if (size_valid_o) begin
        s_sv++;
        if (pv && size_data_o !== sd) s_unstable++;
      end
      pv = size_valid_o;
      sd = size_data_o;
      if (size_valid_o && size_ready_i) begin
        s_size++;
        s_word = size_data_o;
      end
      if (pel_in_ready_o && s_size == 0) s_early++;
      if (pel_in_valid_i && pel_in_ready_o) begin
        s_pix++;
        s_last_pix = cyc;
      end else if (pel_in_valid_i && s_pix >= tot) begin
        s_blocked++;
      end
      if (res_valid_i && res_ready_i) begin
        s_res++;
        s_last_res = cyc;
      end
      if (done_o) begin
        s_done++;
        s_done_cyc = cyc;
        seen = 1;
      end
      if (clr_cyc >= 0 && cyc == clr_cyc + 1) break;
      cyc++;
    end
    if (clr_at < 0) begin
      total_n++;
      if (!seen) begin
        bad_n++;
        $display("FAIL job_timeout w=%0d h=%0d got=none req=done",
                 w, h);
      end
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    pel_in_valid_i  = 1;
    pel_out_ready_i = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total_n++;
    if (idle_o !== 1'b1) begin
      bad_n++;
      $display("FAIL rst_idle got=%b req=1", idle_o);
    end
    total_n++;
    if ({busy_o, done_o, err_o, size_valid_o}
        !== 4'b0) begin
      bad_n++;
      $display("FAIL rst_flags got=%b req=0000",
               {busy_o, done_o, err_o, size_valid_o});
    end
    total_n++;
    if ({pel_in_ready_o, pel_out_valid_o} !== 2'b0) begin
      bad_n++;
      $display("FAIL rst_gate got=%b req=00",
               {pel_in_ready_o, pel_out_valid_o});
    end
    total_n++;
    if (cnt_in_o !== '0 || cnt_out_o !== '0
        || size_data_o !== '0) begin
      bad_n++;
      $display("FAIL rst_cnt got=%0d/%0d/%h req=0",
               cnt_in_o, cnt_out_o, size_data_o);
    end
    drive_idle();
    rst_ni = 1;
    mon_en = 1;
  endtask

  task automatic test_basic();
    int lat;
    run_job(4, 3, 100, 100, 100, 0, -1, -1, 0);
    lat = (s_last_res > s_last_pix ? s_last_res
                                   : s_last_pix) + 1;
    total_n++;
    if (s_size !== 1 || s_word !== 32'h0003_0004) begin
      bad_n++;
      $display("FAIL basic_size got=%0d/%h req=1/00030004",
               s_size, s_word);
    end
    total_n++;
    if (s_pix !== 12) begin
      bad_n++;
      $display("FAIL basic_pix got=%0d req=12", s_pix);
    end
    total_n++;
    if (s_blocked < 1) begin
      bad_n++;
      $display("FAIL basic_13th got=%0d req>=1", s_blocked);
    end
    total_n++;
    if (s_done !== 1 || s_done_cyc !== lat) begin
      bad_n++;
      $display("FAIL basic_done got=%0d@%0d req=1@%0d",
               s_done, s_done_cyc, lat);
    end
    total_n++;
    if (cnt_in_o !== 12 || cnt_out_o !== 12) begin
      bad_n++;
      $display("FAIL basic_cnt got=%0d/%0d req=12/12",
               cnt_in_o, cnt_out_o);
    end
  endtask

  task automatic test_size_stall();
    run_job(3, 2, 100, 100, 100, 5, -1, -1, 0);
    total_n++;
    if (s_sv !== 6 || s_unstable !== 0) begin
      bad_n++;
      $display("FAIL stall_size got=%0d/%0d req=6/0",
               s_sv, s_unstable);
    end
    total_n++;
    if (s_early !== 0) begin
      bad_n++;
      $display("FAIL stall_early got=%0d req=0", s_early);
    end
    total_n++;
    if (s_word !== 32'h0002_0003 || s_pix !== 6) begin
      bad_n++;
      $display("FAIL stall_job got=%h/%0d req=00020003/6",
               s_word, s_pix);
    end
  endtask

  task automatic test_zero();
    run_job(0, 7, 100, 100, 100, 0, -1, -1, 0);
    total_n++;
    if (s_sv !== 0 || s_pix !== 0) begin
      bad_n++;
      $display("FAIL zero_traffic got=%0d/%0d req=0/0",
               s_sv, s_pix);
    end
    total_n++;
    if (s_done !== 1 || s_done_cyc !== 1) begin
      bad_n++;
      $display("FAIL zero_done got=%0d@%0d req=1@1",
               s_done, s_done_cyc);
    end
    total_n++;
    if (err_o !== 1'b0) begin
      bad_n++;
      $display("FAIL zero_err got=%b req=0", err_o);
    end
  endtask

  task automatic test_clear();
    run_job(4, 3, 100, 100, 100, 0, -1, 5, 0);
    total_n++;
    if (idle_o !== 1 || done_o !== 0 || s_done !== 0) begin
      bad_n++;
      $display("FAIL clr_state got=%b/%b/%0d req=1/0/0",
               idle_o, done_o, s_done);
    end
    total_n++;
    if (cnt_in_o !== 0 || cnt_out_o !== 0) begin
      bad_n++;
      $display("FAIL clr_cnt got=%0d/%0d req=0/0",
               cnt_in_o, cnt_out_o);
    end
    total_n++;
    if (pel_in_ready_o !== 0 || s_pix !== 5) begin
      bad_n++;
      $display("FAIL clr_gate got=%b/%0d req=0/5",
               pel_in_ready_o, s_pix);
    end
    run_job(2, 2, 100, 100, 100, 0, -1, -1, 0);
    total_n++;
    if (s_pix !== 4 || s_done !== 1 || cnt_in_o !== 4) begin
      bad_n++;
      $display("FAIL clr_next got=%0d/%0d/%0d req=4/1/4",
               s_pix, s_done, cnt_in_o);
    end
  endtask

  task automatic test_extra_result();
    run_job(4, 3, 100, 100, 100, 0, -1, -1, 0);
    @(posedge clk_i); #1;
    res_valid_i = 1;
    res_ready_i = 1;
    @(posedge clk_i); #1;
    drive_idle();
    @(negedge clk_i);
    total_n++;
    if (err_o !== 1 || cnt_out_o !== 12) begin
      bad_n++;
      $display("FAIL extra_err got=%b/%0d req=1/12",
               err_o, cnt_out_o);
    end
    repeat (3) @(negedge clk_i);
    total_n++;
    if (err_o !== 1) begin
      bad_n++;
      $display("FAIL extra_sticky got=%b req=1", err_o);
    end
    run_job(1, 1, 100, 100, 100, 0, -1, -1, 0);
    total_n++;
    if (err_o !== 0) begin
      bad_n++;
      $display("FAIL extra_restart got=%b req=0", err_o);
    end
  endtask

  task automatic test_mid_start();
    run_job(4, 3, 100, 100, 100, 0, 5, -1, 0);
    total_n++;
    if (s_pix !== 12 || cnt_in_o !== 12 || s_done !== 1) begin
      bad_n++;
      $display("FAIL mid_job got=%0d/%0d/%0d req=12/12/1",
               s_pix, cnt_in_o, s_done);
    end
  endtask

  task automatic test_random();
    int w, h, tot, lat;
    bit ex;
    for (int j = 0; j < 30; j++) begin
      w  = $urandom_range(0, 5);
      h  = $urandom_range(0, 5);
      ex = ($urandom_range(0, 3) == 0);
      tot = w * h;
      run_job(w, h, $urandom_range(40, 100),
              $urandom_range(40, 100),
              $urandom_range(40, 100),
              $urandom_range(0, 4),
              ($urandom_range(0, 2) == 0) ? 2 : -1,
              -1, ex);
      lat = (s_last_res > s_last_pix ? s_last_res
                                     : s_last_pix) + 1;
      total_n++;
      if (s_pix !== tot || s_done !== 1
          || s_size !== (tot != 0)) begin
        bad_n++;
        $display("FAIL rnd_job%0d got=%0d/%0d/%0d req=%0d/1/%0d",
                 j, s_pix, s_done, s_size, tot, tot != 0);
      end
      if (!ex && tot != 0) begin
        total_n++;
        if (s_done_cyc !== lat) begin
          bad_n++;
          $display("FAIL rnd_lat%0d got=%0d req=%0d",
                   j, s_done_cyc, lat);
        end
      end
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_size_stall();
    test_zero();
    test_clear();
    test_extra_result();
    test_mid_start();
    test_random();
    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d",
             total_n, bad_n);
    $finish;
  end

endmodule
